// File: rtl/mb_lane_serializer_if.sv
// Parallel word handshake between the mainband TX datapath and the lane serializer.
interface mb_lane_serializer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_par_data;
  logic             i_par_valid;
  logic             o_par_ready;

  modport master (output i_par_data, output i_par_valid, input  o_par_ready);
  modport slave  (input  i_par_data, input  i_par_valid, output o_par_ready);
endinterface

// File: rtl/mb_lane_serializer.sv
// Mainband lane TX serializer: WIDTH-bit words in over valid/ready, out MSB first one bit per pll_clk,
// first bit the cycle after acceptance; a one-entry hold keeps streams gapless and ready drops while it is full.
module mb_lane_serializer #(
  parameter int WIDTH        = 32,
  parameter int TRAIL_CYCLES = 4
) (
  input  logic                 pll_clk,
  input  logic                 i_rst,
  mb_lane_serializer_if.slave  par_if,
  output logic                 o_ser_data,
  output logic                 o_ser_valid,
  output logic                 o_word_last,
  output logic                 o_clk_en,
  output logic                 o_busy
);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_last_q, word_last_d;
  logic             clk_en_q, clk_en_d;
  logic             busy_q, busy_d;
  logic             xfer;
  logic             last_bit;
  logic             trail_done;

  assign par_if.o_par_ready = !hold_valid_q;
  assign xfer     = par_if.i_par_valid && !hold_valid_q;
  assign last_bit = (bit_cnt_q == BW'(WIDTH - 1));

  always_comb begin
    state_d      = state_q;
    shift_reg_d  = shift_reg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    bit_cnt_d    = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d     = SHIFT;
          shift_reg_d = par_if.i_par_data;
          bit_cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          // Held word has priority; ready is low then, so no new word can race it.
          if (hold_valid_q) begin
            shift_reg_d  = hold_q;
            hold_valid_d = 1'b0;
          end else if (xfer) begin
            shift_reg_d = par_if.i_par_data;
          end else begin
            state_d = (TRAIL_CYCLES > 0) ? TRAIL : IDLE;
          end
        end else begin
          shift_reg_d = shift_reg_q << 1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          if (xfer) begin
            hold_d       = par_if.i_par_data;
            hold_valid_d = 1'b1;
          end
        end
      end
      TRAIL: begin
        if (xfer) begin
          state_d     = SHIFT;
          shift_reg_d = par_if.i_par_data;
          bit_cnt_d   = '0;
        end else if (trail_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with state_q.
    ser_valid_d = (state_d == SHIFT);
    ser_data_d  = ser_valid_d && shift_reg_d[WIDTH-1];
    word_last_d = ser_valid_d && (bit_cnt_d == BW'(WIDTH - 1));
    clk_en_d    = (state_d != IDLE);
    busy_d      = (state_d != IDLE) || hold_valid_d;
  end

  generate
    if (TRAIL_CYCLES > 0) begin : g_trail
      localparam int TW = $clog2(TRAIL_CYCLES + 1);
      logic [TW-1:0] trail_cnt_q, trail_cnt_d;

      always_comb begin
        trail_cnt_d = '0;
        if (state_q == TRAIL && !xfer) begin
          trail_cnt_d = trail_cnt_q + 1'b1;
        end
      end

      always_ff @(posedge pll_clk) begin
        if (i_rst) trail_cnt_q <= '0;
        else       trail_cnt_q <= trail_cnt_d;
      end

      assign trail_done = (trail_cnt_q == TW'(TRAIL_CYCLES - 1));
    end else begin : g_no_trail
      assign trail_done = 1'b1;
    end
  endgenerate

  always_ff @(posedge pll_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      shift_reg_q  <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      ser_data_q   <= 1'b0;
      ser_valid_q  <= 1'b0;
      word_last_q  <= 1'b0;
      clk_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_reg_q  <= shift_reg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      ser_data_q   <= ser_data_d;
      ser_valid_q  <= ser_valid_d;
      word_last_q  <= word_last_d;
      clk_en_q     <= clk_en_d;
      busy_q       <= busy_d;
    end
  end

  assign o_ser_data  = ser_data_q;
  assign o_ser_valid = ser_valid_q;
  assign o_word_last = word_last_q;
  assign o_clk_en    = clk_en_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_mb_lane_serializer.sv
// Bench for mb_lane_serializer: directed words, per-bit scoreboard monitor, plus a TRAIL_CYCLES=0 instance.
module tb_mb_lane_serializer;
  localparam int W = 32;

  logic pll_clk = 1'b0;
  logic i_rst;
  always #5 pll_clk = ~pll_clk;

  mb_lane_serializer_if #(.WIDTH(W)) tx_if ();
  mb_lane_serializer_if #(.WIDTH(W)) tx0_if ();

  logic ser_data, ser_valid, word_last, clk_en, busy;
  logic ser_data0, ser_valid0, word_last0, clk_en0, busy0;

  mb_lane_serializer #(.WIDTH(W), .TRAIL_CYCLES(4)) dut (
    .pll_clk     (pll_clk),
    .i_rst       (i_rst),
    .par_if      (tx_if),
    .o_ser_data  (ser_data),
    .o_ser_valid (ser_valid),
    .o_word_last (word_last),
    .o_clk_en    (clk_en),
    .o_busy      (busy)
  );

  mb_lane_serializer #(.WIDTH(W), .TRAIL_CYCLES(0)) dut0 (
    .pll_clk     (pll_clk),
    .i_rst       (i_rst),
    .par_if      (tx0_if),
    .o_ser_data  (ser_data0),
    .o_ser_valid (ser_valid0),
    .o_word_last (word_last0),
    .o_clk_en    (clk_en0),
    .o_busy      (busy0)
  );

  typedef struct packed {
    logic d;
    logic last;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  exp_bit_t mon_e;
  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int run_len  = 0;
  int last_run = 0;

  always @(posedge pll_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every valid serial bit must match the next expected bit.
  always @(negedge pll_clk) begin
    if (i_rst) begin
      run_len = 0;
    end else if (ser_valid) begin
      run_len++;
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ser_data", ser_data, mon_e.d);
        chk("word_last", word_last, mon_e.last);
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      chk("idle_data_last", {ser_data, word_last}, 0);
    end
  end

  task automatic send(input logic [W-1:0] w, output int acc);
    int n = 0;
    tx_if.i_par_data  = w;
    tx_if.i_par_valid = 1'b1;
    while (tx_if.o_par_ready !== 1'b1 && n < 200) begin
      @(negedge pll_clk);
      n++;
    end
    if (n >= 200) begin
      chk("send_timeout", n, 0);
      acc = -1;
      return;
    end
    @(posedge pll_clk);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back('{w[i], (i == 0)});
    @(negedge pll_clk);
    acc = cyc;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge pll_clk);
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, n, gaps;
    i_rst = 1'b1;
    tx_if.i_par_valid  = 1'b0;
    tx_if.i_par_data   = '0;
    tx0_if.i_par_valid = 1'b0;
    tx0_if.i_par_data  = '0;
    repeat (3) @(negedge pll_clk);
    i_rst = 1'b0;
    @(negedge pll_clk);
    chk("rst_outputs", {ser_data, ser_valid, word_last, clk_en, busy}, 0);
    chk("rst_ready", tx_if.o_par_ready, 1);

    // Single word, then count forwarded-clock cycles (32 bits + 4 trail).
    send(32'hA5A5_0F0F, a0);
    tx_if.i_par_valid = 1'b0;
    chk("t1_first_bit", {ser_valid, ser_data}, 2'b11);
    n = 0;
    while (clk_en === 1'b1 && n < 100) begin
      n++;
      @(negedge pll_clk);
    end
    chk("t1_clk_en_cycles", n, 36);
    chk("t1_busy_after", busy, 0);
    chk("t1_drained", exp_q.size(), 0);

    // Back-to-back: second word lands in the hold register.
    send(32'hFFFF_0000, a0);
    send(32'h0000_FFFF, a1);
    tx_if.i_par_valid = 1'b0;
    chk("t2_ready_hold_full", tx_if.o_par_ready, 0);
    chk("t2_accept_gap", a1 - a0, 1);
    wait_idle("t2");
    chk("t2_run_len", last_run, 64);

    // Restart two cycles into the trail.
    send(32'h0000_0001, a0);
    tx_if.i_par_valid = 1'b0;
    gaps = 0;
    repeat (33) begin
      @(negedge pll_clk);
      if (clk_en !== 1'b1) gaps++;
    end
    chk("t3_in_trail", {clk_en, ser_valid}, 2'b10);
    send(32'h8000_0000, a1);
    tx_if.i_par_valid = 1'b0;
    chk("t3_clk_en_gaps", gaps, 0);
    chk("t3_restart_bit", {clk_en, ser_valid, ser_data}, 3'b111);
    chk("t3_restart_cycle", a1 - a0, 34);
    wait_idle("t3");

    // Three words: third waits until the first word's last bit has gone.
    send(32'h1234_5678, a0);
    send(32'h9ABC_DEF0, a1);
    send(32'h0F1E_2D3C, a2);
    tx_if.i_par_valid = 1'b0;
    chk("t4_w3_accept", a2 - a0, 33);
    wait_idle("t4");

    // Reset at bit 10 with a word held; both are dropped.
    send(32'hDEAD_BEEF, a0);
    send(32'h1111_1111, a1);
    repeat (9) @(negedge pll_clk);
    i_rst = 1'b1;
    tx_if.i_par_valid = 1'b0;
    @(posedge pll_clk);
    exp_q.delete();
    @(negedge pll_clk);
    i_rst = 1'b0;
    chk("t5_rst_outputs", {ser_data, ser_valid, word_last, clk_en, busy}, 0);
    chk("t5_rst_ready", tx_if.o_par_ready, 1);
    send(32'h0000_0003, a0);
    tx_if.i_par_valid = 1'b0;
    wait_idle("t5");

    // No-trail build: clock enable drops right after the last bit.
    tx0_if.i_par_data  = 32'h0000_00C3;
    tx0_if.i_par_valid = 1'b1;
    @(posedge pll_clk);
    @(negedge pll_clk);
    tx0_if.i_par_valid = 1'b0;
    n = 0;
    while (word_last0 !== 1'b1 && n < 100) begin
      @(negedge pll_clk);
      n++;
    end
    chk("t6_last_at", n, 31);
    chk("t6_last_bit", {clk_en0, ser_valid0, ser_data0}, 3'b111);
    @(negedge pll_clk);
    chk("t6_clk_en_after_last", {clk_en0, ser_valid0, busy0}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
